// File: rtl/router_fsm.sv
// Packet-level controller of the 1x3 router: sequences header, payload, full-stall
// and parity phases, and produces the router_sync and datapath phase strobes.
module router_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       write_enb_reg,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       busy
);

    localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] LOAD_DATA          = 3'd2;
    localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd3;
    localparam logic [2:0] FIFO_FULL_STATE    = 3'd4;
    localparam logic [2:0] LOAD_AFTER_FULL    = 3'd5;
    localparam logic [2:0] LOAD_PARITY        = 3'd6;
    localparam logic [2:0] CHECK_PARITY_ERROR = 3'd7;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [1:0] addr_q;
    logic [1:0] addr_d;
    logic       empty_sel_s;
    logic       soft_sel_s;
    logic       empty_hdr_s;
    logic       hdr_ok_s;
    logic [7:0] outs_q;

    // Output vector order: {detect_add, write_enb_reg, lfd, ld, laf, full, rst_int, busy}
    function automatic logic [7:0] decode_outputs(input logic [2:0] st);
        logic [7:0] v;
        v    = 8'b0000_0000;
        v[7] = (st == DECODE_ADDRESS);
        v[6] = (st == LOAD_DATA) || (st == LOAD_PARITY) || (st == LOAD_AFTER_FULL);
        v[5] = (st == LOAD_FIRST_DATA);
        v[4] = (st == LOAD_DATA);
        v[3] = (st == LOAD_AFTER_FULL);
        v[2] = (st == FIFO_FULL_STATE);
        v[1] = (st == CHECK_PARITY_ERROR);
        v[0] = (st != DECODE_ADDRESS) && (st != LOAD_DATA);
        return v;
    endfunction

    // Select the empty/soft-reset flags of the latched port and of the incoming header.
    always_comb begin
        empty_sel_s = 1'b0;
        soft_sel_s  = 1'b0;
        empty_hdr_s = 1'b0;
        case (addr_q)
            2'b00:   begin empty_sel_s = fifo_empty_0; soft_sel_s = soft_reset_0; end
            2'b01:   begin empty_sel_s = fifo_empty_1; soft_sel_s = soft_reset_1; end
            2'b10:   begin empty_sel_s = fifo_empty_2; soft_sel_s = soft_reset_2; end
            default: begin empty_sel_s = 1'b0;         soft_sel_s = 1'b0;         end
        endcase
        case (data_in)
            2'b00:   empty_hdr_s = fifo_empty_0;
            2'b01:   empty_hdr_s = fifo_empty_1;
            2'b10:   empty_hdr_s = fifo_empty_2;
            default: empty_hdr_s = 1'b0;
        endcase
    end

    assign hdr_ok_s = pkt_valid && (data_in != 2'b11);

    // Next-state and address-capture logic; a soft reset of the active port aborts the packet.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if ((state_q != DECODE_ADDRESS) && soft_sel_s) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (hdr_ok_s) begin
                        addr_d  = data_in;
                        state_d = empty_hdr_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end else begin
                        state_d = DECODE_ADDRESS;
                    end
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                FIFO_FULL_STATE: state_d = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_d = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY:    state_d = empty_sel_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                default:            state_d = DECODE_ADDRESS;
            endcase
        end
    end

    // State, address and registered Moore outputs (decoded from the state being entered).
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'b00;
            outs_q  <= decode_outputs(DECODE_ADDRESS);
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            outs_q  <= decode_outputs(state_d);
        end
    end

    assign detect_add    = outs_q[7];
    assign write_enb_reg = outs_q[6];
    assign lfd_state     = outs_q[5];
    assign ld_state      = outs_q[4];
    assign laf_state     = outs_q[3];
    assign full_state    = outs_q[2];
    assign rst_int_reg   = outs_q[1];
    assign busy          = outs_q[0];

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: a phase-level reference model pushes the expected
// output vector every cycle and an independent monitor pops and compares after each edge.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'b00;
    logic       fifo_full = 1'b0;
    logic [2:0] fifo_empty = 3'b111;
    logic [2:0] soft_reset = 3'b000;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       detect_add, write_enb_reg, lfd_state, ld_state;
    logic       laf_state, full_state, rst_int_reg, busy;

    typedef enum int {P_DA, P_LFD, P_LD, P_WTE, P_FFS, P_LAF, P_LP, P_CPE} phase_t;

    phase_t     m_phase = P_DA;
    int         m_port = 0;
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         passed = 0;
    int         cycle = 0;

    router_fsm dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full),
        .fifo_empty_0(fifo_empty[0]), .fifo_empty_1(fifo_empty[1]), .fifo_empty_2(fifo_empty[2]),
        .soft_reset_0(soft_reset[0]), .soft_reset_1(soft_reset[1]), .soft_reset_2(soft_reset[2]),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .write_enb_reg(write_enb_reg), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clock = ~clock;

    // Expected strobes for a packet phase: {detect_add, wen, lfd, ld, laf, full, rst_int, busy}
    function automatic logic [7:0] phase_outputs(input phase_t p);
        logic idle_or_streaming;
        idle_or_streaming = (p == P_DA) || (p == P_LD);
        return {p == P_DA, p == P_LD || p == P_LP || p == P_LAF, p == P_LFD, p == P_LD,
                p == P_LAF, p == P_FFS, p == P_CPE, !idle_or_streaming};
    endfunction

    // Advance the reference model by one edge using the inputs currently applied.
    task automatic model_step();
        phase_t nxt;
        nxt = m_phase;
        if (reset) begin
            nxt    = P_DA;
            m_port = 0;
        end else if (m_phase != P_DA && soft_reset[m_port]) begin
            nxt = P_DA;
        end else begin
            case (m_phase)
                P_DA:  if (pkt_valid && data_in != 2'd3) begin
                           m_port = int'(data_in);
                           nxt = fifo_empty[m_port] ? P_LFD : P_WTE;
                       end
                P_LFD: nxt = P_LD;
                P_LD:  nxt = fifo_full ? P_FFS : (!pkt_valid ? P_LP : P_LD);
                P_FFS: nxt = fifo_full ? P_FFS : P_LAF;
                P_LAF: nxt = parity_done ? P_DA : (low_pkt_valid ? P_LP : P_LD);
                P_LP:  nxt = P_CPE;
                P_CPE: nxt = fifo_full ? P_FFS : P_DA;
                P_WTE: nxt = fifo_empty[m_port] ? P_LFD : P_WTE;
                default: nxt = P_DA;
            endcase
        end
        m_phase = nxt;
    endtask

    task automatic tick();
        model_step();
        exp_q.push_back(phase_outputs(m_phase));
        @(negedge clock);
    endtask

    task automatic drive(input logic rst, input logic pv, input logic [1:0] din,
                         input logic full, input logic [2:0] emp, input logic [2:0] srst,
                         input logic pd, input logic lpv, input int n);
        reset = rst; pkt_valid = pv; data_in = din; fifo_full = full;
        fifo_empty = emp; soft_reset = srst; parity_done = pd; low_pkt_valid = lpv;
        for (int k = 0; k < n; k++) tick();
    endtask

    // Monitor: the DUT presents a full output vector after every edge.
    always @(posedge clock) begin
        logic [7:0] act;
        logic [7:0] exp;
        #1;
        cycle++;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = {detect_add, write_enb_reg, lfd_state, ld_state,
                   laf_state, full_state, rst_int_reg, busy};
            checks++;
            if (act === exp) passed++;
            else $display("FAIL outputs cycle %0d: got %b expected %b", cycle, act, exp);
        end
    end

    initial begin
        @(negedge clock);
        // Reset, then basic packet to port 1 with 3 LD cycles.
        drive(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 2'd1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 3);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 4);
        // Busy destination: port 2 not empty for 5 cycles, then empty.
        drive(1'b0, 1'b1, 2'd2, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 5);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 3);
        // Full stall for 4 cycles, LAF returns to LD; then again with low_pkt_valid.
        drive(1'b0, 1'b1, 2'd0, 1'b1, 3'b100, 3'b000, 1'b0, 1'b0, 4);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 2'd0, 1'b1, 3'b100, 3'b000, 1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b1, 4);
        // Invalid address is ignored.
        drive(1'b0, 1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, 3);
        // Soft reset: wrong port has no effect, own port aborts.
        drive(1'b0, 1'b1, 2'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 3'b001, 3'b010, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 2'd0, 1'b1, 3'b001, 3'b001, 1'b0, 1'b0, 1);
        // Parity_done and low_pkt_valid together in LAF, then reset during FFS.
        drive(1'b0, 1'b1, 2'd0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 2'd0, 1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 2'd0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b1, 2);
        drive(1'b0, 1'b1, 2'd1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 2'd0, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 2);
        drive(1'b1, 1'b1, 2'd0, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 1);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                  3'($urandom_range(0, 7)),
                  {$urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                   $urandom_range(0, 19) == 0},
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 1);
        end
        @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
# router_fsm

Packet-level controller of the 1x3 router, directly upstream of `router_sync`. It watches the source handshake (`pkt_valid`, header address bits) and FIFO status, sequences each packet through header, payload, full-stall and parity phases, and produces `detect_add` and `write_enb_reg` for `router_sync` plus the phase strobes the register/datapath block uses. It also drives `busy` back to the source.

## Interface
Parameters: none. State encoding is internal.

Ports:
- `clock`  in  1  single system clock; all logic updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pkt_valid`  in  1  source asserts for the duration of a packet's header and payload bytes.
- `data_in`  in  2  address field of the header byte (`2'b00`/`01`/`10` = port 0/1/2; `2'b11` = invalid).
- `fifo_full`  in  1  full flag of the selected FIFO, from `router_sync`.
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2`  in  1 each  empty flags of the three output FIFOs.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2`  in  1 each  time-out soft resets, from `router_sync`.
- `parity_done`  in  1  datapath has written the parity byte.
- `low_pkt_valid`  in  1  datapath saw `pkt_valid` fall while the FIFO was full.
- `detect_add`  out  1  header address capture strobe to `router_sync`.
- `write_enb_reg`  out  1  FIFO write qualifier to `router_sync`.
- `lfd_state`, `ld_state`, `laf_state`, `full_state`  out  1 each  phase strobes to the datapath.
- `rst_int_reg`  out  1  clears the datapath's internal parity error register.
- `busy`  out  1  source must hold the current byte while this is high.

## Operation
- A 2-bit address register `addr` loads `data_in` in DECODE_ADDRESS when `pkt_valid` is high and `data_in != 2'b11`. `empty_sel` = `fifo_empty_<addr>`, and `soft_sel` = `soft_reset_<addr>`.
- The block has eight states: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), WAIT_TILL_EMPTY (WTE), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE).
- State transitions:
  - DA: goes to LFD if `pkt_valid` is high, `data_in != 3` and `fifo_empty_<data_in>` is high. Goes to WTE if `pkt_valid` is high, `data_in != 3` and that FIFO is not empty. Otherwise stays in DA, so an address of 3 causes the header to be ignored.
  - LFD: goes to LD unconditionally.
  - LD: goes to FFS if `fifo_full`. Otherwise goes to LP if `!pkt_valid`. Otherwise stays in LD.
  - FFS: goes to LAF if `!fifo_full`. Otherwise stays in FFS.
  - LAF: goes to DA if `parity_done`. Otherwise goes to LP if `low_pkt_valid`, or to LD if not.
  - LP: goes to CPE unconditionally.
  - CPE: goes to FFS if `fifo_full`. Otherwise goes to DA.
  - WTE: goes to LFD if `empty_sel`. Otherwise stays in WTE.
- Priority order: `reset` first, then `soft_sel` in any state other than DA (next state is DA), then the normal transitions above.
- Outputs are Moore, decoded from the registered state only:
  - `detect_add` = DA.
  - `lfd_state` = LFD, `ld_state` = LD, `laf_state` = LAF, `full_state` = FFS, `rst_int_reg` = CPE.
  - `write_enb_reg` = LD | LP | LAF.
  - `busy` = 1 in every state except DA and LD.

## Timing
- Reset (sync, active-high):
  - The state register is set to DA and `addr` to 0.
  - On the cycle after the reset edge, `detect_add`=1 and every other output is 0.
- All state changes take effect on the rising edge of `clock`. Outputs change in the same cycle as the state change, with no extra register stage.
- Header latency: if the target FIFO is empty, `pkt_valid` and the header sampled in DA put LFD on the next cycle. `lfd_state` and `busy` are high for exactly 1 cycle, then LD follows.
- End of packet: sampling `pkt_valid`=0 in LD gives LP for 1 cycle (`write_enb_reg`=1, `busy`=1), then CPE for 1 cycle (`rst_int_reg`=1), then DA.
- Full stall: the FSM stays in FFS with `busy`=1 and `write_enb_reg`=0 for as long as `fifo_full`=1, and moves to LAF on the first cycle `fifo_full`=0.
- Simultaneous events:
  - If `soft_sel` and `fifo_full` are both high in LD, the next state is DA.
  - If `parity_done` and `low_pkt_valid` are both high in LAF, the next state is DA.
- A reset asserted mid-packet forces DA on the next edge regardless of state. A packet interrupted this way is abandoned; it is not resumed.

## Test plan
- Basic packet: reset for 1 cycle, then `pkt_valid`=1, `data_in`=2'b01, `fifo_empty_1`=1, and drop `pkt_valid` after 3 LD cycles. Required state sequence is DA→LFD→LD×3→LP→CPE→DA, with `write_enb_reg` high for 4 cycles and `rst_int_reg` high for 1 cycle.
- Busy destination: header 2'b10 with `fifo_empty_2`=0 for 5 cycles → the FSM stays in WTE with `busy`=1 and `detect_add`=0 throughout. Raising `fifo_empty_2` gives LFD on the next cycle.
- Full stall: in LD, assert `fifo_full` for 4 cycles → FFS for 4 cycles with `write_enb_reg`=0, then LAF. With `parity_done`=0 and `low_pkt_valid`=0 the FSM returns to LD; a repeat with `low_pkt_valid`=1 must go to LP.
- Invalid address: `pkt_valid`=1 with `data_in`=2'b11 → the FSM stays in DA with `busy`=0 and `addr` unchanged.
- Soft reset: in LD with `addr`=0, pulse `soft_reset_0` → DA on the next cycle. Pulsing `soft_reset_1` instead must have no effect.
- Reset mid-operation: assert `reset` during FFS → DA on the next cycle with `detect_add`=1 and all other outputs 0.
